// File: rtl/serial_add_sched.sv
// serial_add_sched
//   Scheduler and sequencer for one shared bit-serial adder. Two clients
//   present operand pairs over valid/ready. The winner's operands are latched
//   and the adder is sequenced: one parallel-load cycle, then W shift-enable
//   cycles. The adder's parallel result is returned with the requester ID.
//   Only one operation is in flight at a time, so the adder never sees
//   overlapping work.
//
// Configuration:
//   SERIAL_ADD_SCHED_RR_EN  defined   -> round-robin arbitration (last-served
//                                        pointer, requester 0 first after reset)
//                           undefined -> fixed priority, requester 0 wins
//
// Parameters:
//   W            operand/result width, equals the adder width (2..32)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/req0_ready     requester 0 handshake, operands req0_a/req0_b
//   req1_valid/req1_ready     requester 1 handshake, operands req1_a/req1_b
//   rsp_valid/rsp_ready       response handshake
//   rsp_id                    requester that issued the returned result
//   rsp_sum                   (a+b) mod 2^W
//   busy                      high whenever the FSM is not IDLE
//   add_pload, add_enable     adder parallel-load and shift-enable controls
//   add_adata, add_bdata      latched operands driven to the adder
//   add_pout                  adder parallel result

module serial_add_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,

  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,

  output logic         busy,

  output logic         add_pload,
  output logic         add_enable,
  output logic [W-1:0] add_adata,
  output logic [W-1:0] add_bdata,
  input  logic [W-1:0] add_pout
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [CW-1:0] r_bitCnt;
  logic [W-1:0]  r_opA;
  logic [W-1:0]  r_opB;
  logic          r_id;

  logic          w_grant;
  logic          w_anyValid;
  logic          w_accept;
  logic          w_lastBit;

  // ---------------------------------------------------------------------------
  // Arbitration. w_grant names the requester that would be served this cycle;
  // it only matters when at least one requester is valid.
  // ---------------------------------------------------------------------------
`ifdef SERIAL_ADD_SCHED_RR_EN
  logic r_lastServed;

  // On contention the requester that was not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_lastServed;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Pointer resets to 1 so requester 0 has first priority; it moves only on
  // an actual accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastServed <= 1'b1;
    end else if (w_accept) begin
      r_lastServed <= w_grant;
    end
  end
`else
  // Fixed priority: requester 1 is chosen only when requester 0 is idle.
  assign w_grant = ~req0_valid;
`endif

  assign w_anyValid = req0_valid | req1_valid;

  // Ready is combinational from state, so gate with rst to keep both readies
  // low during the reset cycle.
  assign w_accept   = (r_state == IDLE) && w_anyValid && !rst;

  assign w_lastBit  = (r_bitCnt == CW'(W - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic. DONE always returns through IDLE, so a request
  // arriving together with rsp_ready is accepted one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_nextState = RUN;
      end
      RUN: begin
        if (w_lastBit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand/ID capture and shift counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_id     <= 1'b0;
      r_bitCnt <= '0;
    end else begin
      if (w_accept) begin
        r_opA <= w_grant ? req1_a : req0_a;
        r_opB <= w_grant ? req1_b : req0_b;
        r_id  <= w_grant;
      end
      if (r_state == LOAD) begin
        r_bitCnt <= '0;
      end else if (r_state == RUN) begin
        r_bitCnt <= r_bitCnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM outputs.
  // The adder's final shift lands on the edge that enters DONE, and add_enable
  // is low for the whole of DONE, so add_pout holds the finished sum and is
  // stable for as long as the response is back-pressured. rsp_sum therefore
  // presents add_pout in DONE and zero elsewhere.
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_sum    = '0;
    add_pload  = 1'b0;
    add_enable = 1'b0;
    busy       = (r_state != IDLE);
    rsp_id     = r_id;
    add_adata  = r_opA;
    add_bdata  = r_opB;

    case (r_state)
      IDLE: begin
        req0_ready = w_accept && !w_grant;
        req1_ready = w_accept &&  w_grant;
      end
      LOAD: begin
        add_pload = 1'b1;
      end
      RUN: begin
        add_enable = 1'b1;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_sum   = add_pout;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Two-requester scheduler and sequencer for the shared bit-serial adder datapath. It accepts operand pairs from two clients over valid/ready channels and arbitrates between them. It drives the adder's parallel-load and shift-enable controls for exactly W cycles, captures the parallel result and returns it to the winning client with a requester ID. It sits between client logic and a single serial adder instance, so the adder never sees overlapping operations.

## Interface
- W, default 8: operand/result width; equals the adder's shift-register width; legal range 2..32.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid, req1_valid  in  1 each  requester has an operand pair.
- req0_a, req0_b, req1_a, req1_b  in  W each  operands.
- req0_ready, req1_ready  out  1 each  request accepted this cycle when valid&ready.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result when rsp_valid&rsp_ready.
- rsp_id  out  1  requester that issued the result (0/1).
- rsp_sum  out  W  (a+b) mod 2^W.
- busy  out  1  high in any state other than IDLE.
- add_pload  out  1  to adder parallel-load.
- add_enable  out  1  to adder shift-enable.
- add_adata, add_bdata  out  W each  to adder operand inputs.
- add_pout  in  W  adder parallel result.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - reqN_ready is combinational: state==IDLE and grant==N.
  - At most one ready is high per cycle, and only to a requester with valid high.
  - On accept: latch a, b and id into registers, then go to LOAD.
- LOAD: add_pload=1 for one cycle, add_enable=0; then go to RUN and clear the bit counter.
- RUN: add_enable=1 and add_pload=0 for exactly W cycles. The counter (width clog2(W+1)) increments each cycle; go to DONE on the cycle the counter reads W-1.
- DONE:
  - rsp_valid=1; rsp_sum=add_pout, registered on DONE entry; rsp_id=latched id.
  - Hold all response outputs stable until rsp_ready, then go to IDLE.
  - add_enable=0 in DONE, so the adder's carry flop clears.
- add_adata/add_bdata always drive the latched operands.
- Arbitration with the RR macro:
  - A last-served pointer sets priority; the requester not served last wins when both are valid.
  - The pointer updates only on accept.
- Carry-out is discarded; the sum wraps modulo 2^W (0xFF+0x01 → 0x00 at W=8).
- Requests arriving while busy wait with ready low; clients must hold valid and data stable until accepted.

## Timing
- Reset values: req0_ready=req1_ready=0 (only during the rst cycle), rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0, add_pload=0, add_enable=0, add_adata=add_bdata=0, state=IDLE, pointer=1 (so requester 0 has first priority).
- Timeline for an accept at edge T:
  - LOAD during cycle T..T+1.
  - RUN for W cycles.
  - rsp_valid rises after edge T+1+W.
  - Minimum accept-to-rsp_valid latency: W+2 cycles.
- With rsp_ready held high, the DONE→IDLE handoff adds 1 cycle, so back-to-back throughput is one result per W+3 cycles.
- A new accept is possible in the first IDLE cycle after a response is taken.
- Reset mid-operation (any state): the next edge forces IDLE and all outputs to reset values. The in-flight result is dropped and no rsp_valid is issued. The adder is re-initialised by the next LOAD.
- Simultaneous rsp_ready with a new req_valid in DONE: the response is taken; the request is accepted in the following IDLE cycle, not in DONE.
- rsp_ready while rsp_valid=0 is ignored.

## Configuration
- Macro SERIAL_ADD_SCHED_RR_EN:
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, requester 0 always wins when both are valid. The pointer register is removed; all other behaviour and timing are identical.

## Test plan
- Single request (W=8): req0 a=0x01, b=0x02, both requesters otherwise idle → rsp_valid after W+2 cycles with rsp_sum=0x03, rsp_id=0; add_pload high exactly 1 cycle; add_enable high exactly 8 consecutive cycles.
- Wrap: req1 a=0xFF, b=0x01 → rsp_sum=0x00, rsp_id=1; a=0x7F, b=0x80 → 0xFF.
- Contention, RR build:
  - Both valid continuously with distinct operands → grants alternate 0,1,0,1.
  - The first grant after reset goes to 0.
  - Each result matches its rsp_id's operands.
- Backpressure: hold rsp_ready=0 for 20 cycles in DONE → rsp_valid, rsp_sum and rsp_id stable; reqN_ready stays 0; busy=1; accept proceeds after release.
- Reset mid-RUN (cycle 4 of 8) → next cycle all outputs at reset values, no response for the dropped request; a subsequent request 0x02+0x03 returns 0x05.
- Fixed-priority build (macro undefined): both valid continuously → requester 1 is never granted until req0_valid drops.
